// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue/capture stage wrapped around a 4-bit combinational ALU.
// Requests are buffered in a DEPTH-entry FIFO, issued to the ALU from registers,
// and each result is presented with carry/zero/overflow flags on a valid/ready port.
// A 4-bit accumulator keeps the last result so a request can chain on it (use_acc).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake; req_a, req_b, req_sel, req_use_acc
//   alu_a, alu_b, alu_sel    registered operands/select driven to the ALU
//   alu_out, alu_carry       ALU result and carry/borrow
//   res_valid/res_ready      result handshake; res_data, res_carry, res_zero, res_ovf
//   busy, fifo_count         activity and FIFO occupancy
// Optional: define ALU_SEQ_OVF_EN to compute signed overflow on add/sub
// (otherwise res_ovf is tied to 0).
module alu_op_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [3:0]             req_a,
   input  logic [3:0]             req_b,
   input  logic [2:0]             req_sel,
   input  logic                   req_use_acc,
   output logic [3:0]             alu_a,
   output logic [3:0]             alu_b,
   output logic [2:0]             alu_sel,
   input  logic [3:0]             alu_out,
   input  logic                   alu_carry,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [3:0]             res_data,
   output logic                   res_carry,
   output logic                   res_zero,
   output logic                   res_ovf,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [2:0] SEL_IDLE = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      HOLD
   } state_t;

   state_t        state;

   // Entry layout: {use_acc, sel[2:0], b[3:0], a[3:0]}
   logic [11:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [3:0]    acc;
   logic          push;
   logic          pop;
   logic          empty;
   logic [11:0]   head;
   logic [3:0]    issue_a;

   assign empty     = (fifo_count == '0);
   assign req_ready = (fifo_count < FULL);
   assign push      = req_valid & req_ready;
   // Pop only when the ALU registers are free to be reloaded.
   assign pop       = !empty &&
                      ((state == IDLE) || (state == HOLD && res_ready));
   assign head      = mem[rd_ptr];
   // acc already holds the previous result by the time a pop happens.
   assign issue_a   = head[11] ? acc : head[3:0];
   assign busy      = !empty || (state != IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {req_use_acc, req_sel, req_b, req_a};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= SEL_IDLE;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_carry <= 1'b0;
         res_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  alu_a   <= issue_a;
                  alu_b   <= head[7:4];
                  alu_sel <= head[10:8];
                  state   <= DRIVE;
               end
            end
            DRIVE: begin
               res_data  <= alu_out;
               res_carry <= alu_carry;
               res_zero  <= (alu_out == 4'h0);
               acc       <= alu_out;
               res_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (pop) begin
                     alu_a   <= issue_a;
                     alu_b   <= head[7:4];
                     alu_sel <= head[10:8];
                     state   <= DRIVE;
                  end else begin
                     alu_sel <= SEL_IDLE;
                     state   <= IDLE;
                  end
               end
            end
            default: begin
               alu_sel <= SEL_IDLE;
               state   <= IDLE;
            end
         endcase
      end
   end

`ifdef ALU_SEQ_OVF_EN
   logic ovf_next;

   // Signed overflow from the issued operand MSBs and the result MSB.
   always_comb begin
      ovf_next = 1'b0;
      case (alu_sel)
         3'b000:  ovf_next = (alu_a[3] == alu_b[3]) &&
                             (alu_out[3] != alu_a[3]);
         3'b001:  ovf_next = (alu_a[3] != alu_b[3]) &&
                             (alu_out[3] != alu_a[3]);
         default: ovf_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_ovf <= 1'b0;
      end else if (state == DRIVE) begin
         res_ovf <= ovf_next;
      end
   end
`else
   assign res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed bench with ALU model and result scoreboard.
// Expected results are queued at request drive time and compared on handshake.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [3:0] req_a = '0;
   logic [3:0] req_b = '0;
   logic [2:0] req_sel = '0;
   logic       req_use_acc = 1'b0;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_sel;
   logic [3:0] alu_out;
   logic       alu_carry;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [3:0] res_data;
   logic       res_carry;
   logic       res_zero;
   logic       res_ovf;
   logic       busy;
   logic [2:0] fifo_count;

   typedef struct packed {
      logic [3:0] d;
      logic       c;
      logic       z;
      logic       o;
   } res_t;

   res_t       sb[$];
   int         hs_cyc[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [3:0] acc_m = '0;
   res_t       mon_e;

   alu_op_sequencer #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .req_use_acc(req_use_acc),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_carry(alu_carry),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_carry(res_carry),
      .res_zero(res_zero), .res_ovf(res_ovf),
      .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference 4-bit ALU: {carry, result}; borrow on subtract.
   function automatic logic [4:0] alu_f(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic [2:0] s);
      case (s)
         3'b000:  return {1'b0, a} + {1'b0, b};
         3'b001:  return {1'b0, a} - {1'b0, b};
         3'b010:  return {1'b0, a & b};
         3'b011:  return {1'b0, a | b};
         3'b100:  return {1'b0, a ^ b};
         3'b101:  return {1'b0, ~a};
         default: return 5'd0;
      endcase
   endfunction

   function automatic logic ovf_f(input logic [3:0] a, input logic [3:0] b,
                                  input logic r3, input logic [2:0] s);
`ifdef ALU_SEQ_OVF_EN
      if (s == 3'b000) return (a[3] == b[3]) && (r3 != a[3]);
      if (s == 3'b001) return (a[3] != b[3]) && (r3 != a[3]);
      return 1'b0;
`else
      return 1'b0 & (a[0] ^ b[0] ^ r3 ^ s[0]);
`endif
   endfunction

   always_comb begin
      {alu_carry, alu_out} = alu_f(alu_a, alu_b, alu_sel);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         hs_cyc.push_back(cyc);
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_result: observed %0h expected none",
                   res_data);
         end
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("result", {res_data, res_carry, res_zero, res_ovf}, mon_e);
         end
      end
   end

   task automatic push(input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] s, input logic u);
      logic [3:0] ea;
      logic [4:0] r;
      res_t       e;
      ea   = u ? acc_m : a;
      r    = alu_f(ea, b, s);
      e.d  = r[3:0];
      e.c  = r[4];
      e.z  = (r[3:0] == 4'h0);
      e.o  = ovf_f(ea, b, r[3], s);
      sb.push_back(e);
      acc_m = r[3:0];
      req_a = a;
      req_b = b;
      req_sel = s;
      req_use_acc = u;
      req_valid = 1'b1;
      for (int n = 0; n < 100 && !req_ready; n++) @(negedge clk);
      chk("push_ready", req_ready, 1'b1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && (sb.size() != 0 || res_valid || busy); n++)
         @(negedge clk);
      @(posedge clk);
      #1;
      chk("drain_sb", sb.size(), 0);
      chk("drain_busy", busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_fifo_count", fifo_count, 3'd0);
      chk("rst_alu_sel", alu_sel, 3'b111);
      chk("rst_alu_a", alu_a, 4'h0);
      chk("rst_alu_b", alu_b, 4'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_res_data", res_data, 4'h0);
      chk("rst_flags", {res_carry, res_zero, res_ovf}, 3'b000);
      chk("rst_req_ready", req_ready, 1'b1);
      rst = 1'b0;

      // Latency: accept at E0, issue at E1, result valid after E2.
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      push(4'h7, 4'h9, 3'b000, 1'b0);
      chk("lat_e0_count", fifo_count, 3'd1);
      chk("lat_e0_busy", busy, 1'b1);
      chk("lat_e0_valid", res_valid, 1'b0);
      @(posedge clk);
      #1;
      chk("lat_e1_ops", {alu_a, alu_b, alu_sel}, {4'h7, 4'h9, 3'b000});
      chk("lat_e1_count", fifo_count, 3'd0);
      chk("lat_e1_valid", res_valid, 1'b0);
      @(posedge clk);
      #1;
      chk("lat_e2_valid", res_valid, 1'b1);
      chk("lat_e2_res", {res_data, res_carry, res_zero, res_ovf},
          {4'h0, 1'b1, 1'b1, 1'b0});
      @(posedge clk);
      #1;
      chk("lat_e3_valid", res_valid, 1'b0);
      chk("lat_e3_sel", alu_sel, 3'b111);
      chk("lat_e3_busy", busy, 1'b0);

      // Subtract with borrow, then signed-overflow case.
      push(4'h3, 4'h5, 3'b001, 1'b0);
      drain();
      push(4'h7, 4'h8, 3'b001, 1'b0);
      drain();

      // Chain through the accumulator.
      push(4'h5, 4'h6, 3'b000, 1'b0);
      push(4'h0, 4'h3, 3'b100, 1'b1);
      for (int n = 0; n < 50 && alu_sel !== 3'b100; n++) @(negedge clk);
      chk("chain_sel", alu_sel, 3'b100);
      chk("chain_alu_a", alu_a, 4'hB);
      drain();

      // Fill with the consumer stalled, then backpressure hold.
      res_ready = 1'b0;
      push(4'h5, 4'h3, 3'b110, 1'b0);
      push(4'h2, 4'h3, 3'b000, 1'b0);
      push(4'h9, 4'h4, 3'b101, 1'b0);
      push(4'hC, 4'hA, 3'b010, 1'b0);
      push(4'hC, 4'h3, 3'b011, 1'b0);
      chk("fill_ready", req_ready, 1'b0);
      chk("fill_count", fifo_count, 3'd4);
      chk("fill_valid", res_valid, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("bp_valid", res_valid, 1'b1);
         chk("bp_res", {res_data, res_carry, res_zero}, {4'h0, 1'b0, 1'b1});
         chk("bp_count", fifo_count, 3'd4);
         chk("bp_sel", alu_sel, 3'b110);
      end
      hs_cyc.delete();
      res_ready = 1'b1;
      drain();
      chk("tput_n", hs_cyc.size(), 5);
      for (int i = 1; i < hs_cyc.size(); i++)
         chk("tput_gap", hs_cyc[i] - hs_cyc[i-1], 2);

      // Reset while in DRIVE with two entries still queued.
      res_ready = 1'b0;
      push(4'h1, 4'h1, 3'b000, 1'b0);
      push(4'h2, 4'h1, 3'b000, 1'b0);
      push(4'h3, 4'h1, 3'b000, 1'b0);
      push(4'h4, 4'h1, 3'b000, 1'b0);
      chk("pre_rst_count", fifo_count, 3'd3);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("drive_count", fifo_count, 3'd2);
      chk("drive_valid", res_valid, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      acc_m = 4'h0;
      chk("mid_rst_valid", res_valid, 1'b0);
      chk("mid_rst_count", fifo_count, 3'd0);
      chk("mid_rst_sel", alu_sel, 3'b111);
      chk("mid_rst_busy", busy, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("post_rst_quiet", {res_valid, busy}, 2'b00);
      end
      // Accumulator cleared by reset: 0 + 4.
      push(4'h9, 4'h4, 3'b000, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream issue/capture stage wrapped around the 4-bit combinational ALU.
- Buffers operation requests in a small FIFO, drives the ALU operand/select inputs from registers, and captures the ALU result and carry.
- Presents each result with zero/carry flags on a valid/ready output.
- Keeps a 4-bit accumulator (last result) that a request may select as operand A, for chained operations.

Parameters:
- DEPTH, 4, request FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept (count < DEPTH)
- req_a  in  4  operand A
- req_b  in  4  operand B
- req_sel  in  3  ALU select code (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, others give 0)
- req_use_acc  in  1  1 = replace operand A with accumulator at issue time
- alu_a  out  4  registered operand to ALU
- alu_b  out  4  registered operand to ALU
- alu_sel  out  3  registered select to ALU
- alu_out  in  4  ALU result
- alu_carry  in  1  ALU carry/borrow
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_data  out  4  captured result
- res_carry  out  1  captured carry (borrow on sub)
- res_zero  out  1  res_data == 0
- res_ovf  out  1  signed overflow (see Optional Feature)
- busy  out  1  FIFO non-empty or FSM not IDLE
- fifo_count  out  $clog2(DEPTH)+1  entries queued

Behaviour:
- Reset (synchronous, rst high at edge): FIFO empty, fifo_count=0, state IDLE, accumulator=0, alu_a=alu_b=0, alu_sel=3'b111, res_valid=0, res_data=0, res_carry=0, res_zero=0, res_ovf=0, busy=0. Reset mid-operation discards queued and in-flight requests; no result is emitted.
- FIFO push when req_valid & req_ready.
  - req_ready = (count < DEPTH); it does not depend on a same-cycle pop, so there is no pass-through when full.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, DRIVE, HOLD:
  - IDLE: if FIFO non-empty, pop head, load alu_a (accumulator if use_acc else req_a), alu_b, alu_sel; go to DRIVE.
  - DRIVE (exactly one cycle): the ALU settles combinationally. At the end of the cycle, capture res_data=alu_out, res_carry=alu_carry, res_zero, res_ovf, and accumulator=alu_out. Set res_valid=1 and go to HOLD.
  - HOLD: outputs stable while res_valid & !res_ready.
    - On res_ready with FIFO non-empty: pop next, load ALU regs, go to DRIVE; res_valid=0 next cycle.
    - On res_ready with FIFO empty: res_valid=0, set alu_sel=3'b111, go to IDLE.
- use_acc is resolved at pop, after the previous capture, so chaining needs no stall.
- alu_sel=3'b111 whenever in IDLE, so the ALU outputs 0.
- Latency: a request accepted at edge E0 into an empty, idle block is popped at E1 and appears with res_valid=1 after E2.
- Sustained throughput is one result per 2 cycles with res_ready held high.
- Carry is meaningful only for sel 000/001; for other codes the ALU supplies 0 and it is captured as-is.

Optional Feature:
- Macro ALU_SEQ_OVF_EN.
- Defined: at capture, res_ovf is set as follows, using the issued operands' MSBs and alu_out[3]:
  - add: res_ovf = (a3==b3) & (r3!=a3)
  - sub: res_ovf = (a3!=b3) & (r3!=a3)
  - all other sel codes: res_ovf = 0
- Not defined: res_ovf tied to 0 and no overflow logic is synthesised.

Test Plan:
- Reset then single add a=4'h7, b=4'h9, sel=000 -> res_valid 2 cycles after accept; res_data=0, res_carry=1, res_zero=1, res_ovf=0.
- Sub a=3, b=5, sel=001 -> res_data=4'hE, res_carry=1 (borrow), res_zero=0; with ALU_SEQ_OVF_EN, a=7, b=8 sub -> res_data=4'hF, res_ovf=1.
- Chain: add 5+6 (data=4'hB), then use_acc=1, b=4'h3, sel=100 -> alu_a=4'hB, res_data=4'h8.
- Fill: hold res_ready=0 and push 5 requests -> req_ready low after DEPTH+1 accepted (4 queued + 1 in HOLD), fifo_count=4; release res_ready -> results emerge in order, one per 2 cycles.
- Backpressure: res_ready low for 3 cycles in HOLD -> res_data/res_carry stable, no pop; sel=110 -> res_data=0, res_zero=1.
- Assert rst in DRIVE with 2 queued -> next cycle res_valid=0, fifo_count=0, accumulator=0, alu_sel=3'b111, busy=0.
